// File: rtl/reg_access_ctrl_pkg.sv
// Shared constants and types for the A/B/C register-block access controller.
package reg_access_ctrl_pkg;

  localparam int WORD_SIZE = 19;

  // SEL_NONE is deliberately distinct from every real register select.
  localparam logic [1:0] SEL_NONE   = 2'b00;
  localparam logic [1:0] LOAD_REG_A = 2'b01;
  localparam logic [1:0] LOAD_REG_B = 2'b10;
  localparam logic [1:0] LOAD_REG_C = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } reg_ctrl_state_t;

  function automatic logic is_sel_none(input logic [1:0] sel);
    return sel == SEL_NONE;
  endfunction

endpackage

// File: rtl/reg_access_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant and winner index, searching
// upward from ptr_i and wrapping. The pointer itself is owned by the caller.
module rr_arbiter #(
  parameter int N     = 3,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [PTR_W-1:0] winner_o,
  output logic             valid_o
);

  logic found;
  int   idx;

  // NOTE: every output gets a default before the search loop so no latch is inferred.
  always_comb begin
    grant_o  = '0;
    winner_o = '0;
    found    = 1'b0;
    idx      = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr_i) + i) % N;
      if (!found && req_i[idx]) begin
        found         = 1'b1;
        grant_o[idx]  = 1'b1;
        winner_o      = PTR_W'(idx);
      end
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/reg_access_ctrl.sv
// Serialises all requester accesses to the A/B/C register block through one
// load/read port: IDLE (accept) -> ISSUE (drive block) -> RESP (complete).
module reg_access_ctrl #(
  parameter int NUM_REQ   = 3,
  parameter int WORD_SIZE = reg_access_ctrl_pkg::WORD_SIZE,
  parameter int SEL_W     = 2
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_write,
  input  logic [NUM_REQ*SEL_W-1:0]     req_sel,
  input  logic [NUM_REQ*WORD_SIZE-1:0] req_wdata,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [WORD_SIZE-1:0]         rsp_rdata,
  output logic                         rsp_err,
  output logic                         LOAD_REG,
  output logic [SEL_W-1:0]             LOAD_SELECT,
  output logic [WORD_SIZE-1:0]         data_in,
  input  logic [WORD_SIZE-1:0]         data_out
);

  import reg_access_ctrl_pkg::*;

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  reg_ctrl_state_t        state_q, state_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [PTR_W-1:0]       winner_q, winner_d;
  logic                   write_q, write_d;
  logic [SEL_W-1:0]       sel_q, sel_d;
  logic [WORD_SIZE-1:0]   wdata_q, wdata_d;

  logic [NUM_REQ-1:0]     arb_grant;
  logic [PTR_W-1:0]       arb_winner;
  logic                   arb_valid;
  logic                   sel_none;

  rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req_i    (req_valid),
    .ptr_i    (ptr_q),
    .grant_o  (arb_grant),
    .winner_o (arb_winner),
    .valid_o  (arb_valid)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    winner_d = winner_q;
    write_d  = write_q;
    sel_d    = sel_q;
    wdata_d  = wdata_q;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          state_d  = ISSUE;
          winner_d = arb_winner;
          write_d  = req_write[arb_winner];
          sel_d    = req_sel[arb_winner*SEL_W +: SEL_W];
          wdata_d  = req_wdata[arb_winner*WORD_SIZE +: WORD_SIZE];
          ptr_d    = (arb_winner == PTR_W'(NUM_REQ - 1)) ? '0 : arb_winner + PTR_W'(1);
        end
      end
      ISSUE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      winner_q <= '0;
      write_q  <= 1'b0;
      sel_q    <= SEL_W'(SEL_NONE);
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      winner_q <= winner_d;
      write_q  <= write_d;
      sel_q    <= sel_d;
      wdata_q  <= wdata_d;
    end
  end

  assign sel_none = is_sel_none(sel_q);

  // Ready is masked by reset so a requester holding valid through reset is not accepted.
  assign req_ready   = (state_q == IDLE && RST_N) ? arb_grant : '0;

  assign LOAD_REG    = (state_q == ISSUE) && write_q && !sel_none;
  assign LOAD_SELECT = (state_q == ISSUE) ? sel_q : SEL_W'(SEL_NONE);
  assign data_in     = (state_q == ISSUE) ? wdata_q : '0;

  always_comb begin
    rsp_valid = '0;
    if (state_q == RESP) rsp_valid[winner_q] = 1'b1;
  end

  assign rsp_err   = (state_q == RESP) && sel_none;
  assign rsp_rdata = (state_q == RESP && !write_q && !sel_none) ? data_out : '0;

endmodule
